fetch_ctrl: RTL and testbench

//  Instruction-fetch controller: the writer side of the PC register. Owns the PC

---
 rtl/fetch_ctrl_pkg.sv | 12 +
 rtl/fetch_ctrl_if.sv | 13 +
 rtl/fetch_buf.sv | 60 ++++++
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_ctrl_pkg;
  localparam int              XLEN         = 32;
  localparam int              PC_INC_DEF   = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus: in-order read requests and responses.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_buf.sv
// In-order fetch buffer: entries are allocated with their PC at issue, filled by
// responses in order, and popped from the head; a flush empties it in one cycle.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_alloc,
  input  logic [XLEN-1:0]          i_alloc_pc,
  input  logic                     i_fill,
  input  logic [XLEN-1:0]          i_fill_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_used,
  output logic                     o_head_valid,
  output logic [XLEN-1:0]          o_head_pc,
  output logic [XLEN-1:0]          o_head_instr
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_fill;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_used;

  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr   <= '0;
      r_fill <= '0;
      r_rd   <= '0;
      r_used <= '0;
    end else begin
      if (i_alloc) r_wr   <= r_wr + AW'(1);
      if (i_fill)  r_fill <= r_fill + AW'(1);
      if (i_pop)   r_rd   <= r_rd + AW'(1);
      case ({i_alloc, i_pop})
        2'b10:   r_used <= r_used + (AW+1)'(1);
        2'b01:   r_used <= r_used - (AW+1)'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  // Entry contents carry no reset: r_used gates every read of them.
  always_ff @(posedge clk) begin
    if (i_alloc) r_mem[r_wr] <= '{pc: i_alloc_pc, instr: '0, filled: 1'b0};
    if (i_fill) begin
      r_mem[r_fill].instr  <= i_fill_data;
      r_mem[r_fill].filled <= 1'b1;
    end
  end

  assign o_used       = r_used;
  assign o_head_valid = (r_used != '0) && r_mem[r_rd].filled;
  assign o_head_pc    = r_mem[r_rd].pc;
  assign o_head_instr = r_mem[r_rd].instr;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, issues in-order reads,
// drops responses made stale by redirects and presents {pc, instr} to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              PC_INC   = PC_INC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_q,
  output logic            pc_le,
  output logic [XLEN-1:0] pc_d,
  fetch_ctrl_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = CW + 6;

  logic [CW-1:0] r_outstanding;
  logic [DW-1:0] r_drop_cnt;
  logic [CW-1:0] w_used;
  logic [DW-1:0] w_inflight;
  logic          w_head_valid;
  logic          w_pop;
  logic          w_issue;
  logic          w_accept;
  logic          w_fill;
  logic          w_rsp_take;

  assign w_pop = w_head_valid && if_ready && !redirect_valid;
  // A slot popped this cycle is reusable at once, sustaining one fetch per cycle.
  assign w_issue  = reset && !redirect_valid && !stall && ((w_used < CW'(DEPTH)) || w_pop);
  assign w_accept = w_issue && imem.req_ready;

  assign imem.req_valid = w_issue;
  assign imem.req_addr  = pc_q;

  assign w_inflight = r_drop_cnt + DW'(r_outstanding);
  assign w_rsp_take = imem.rsp_valid && (w_inflight != '0);
  assign w_fill     = imem.rsp_valid && (r_drop_cnt == '0) && (r_outstanding != '0)
                      && !redirect_valid;

  always_comb begin
    pc_le = 1'b0;
    pc_d  = pc_q;
    if (!reset) begin
      pc_le = 1'b1;
      pc_d  = RESET_PC;
    end else if (redirect_valid) begin
      pc_le = 1'b1;
      pc_d  = redirect_pc;
    end else if (w_accept) begin
      pc_le = 1'b1;
      pc_d  = pc_q + XLEN'(PC_INC);
    end
  end

  // Older stale responses always arrive before any fetch issued after a redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      r_outstanding <= '0;
      r_drop_cnt    <= w_inflight - DW'(w_rsp_take);
    end else begin
      case ({w_accept, w_fill})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (imem.rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - DW'(1);
    end
  end

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (redirect_valid),
    .i_alloc      (w_accept),
    .i_alloc_pc   (pc_q),
    .i_fill       (w_fill),
    .i_fill_data  (imem.rsp_data),
    .i_pop        (w_pop),
    .o_used       (w_used),
    .o_head_valid (w_head_valid),
    .o_head_pc    (if_pc),
    .o_head_instr (if_instr)
  );

  assign if_valid = reset && w_head_valid;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an external PC register and an in-order memory model.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_q = 32'h1234_5678;
  logic        pc_le;
  logic [31:0] pc_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        rsp_en;
  int          total = 0;
  int          bad   = 0;

  fetch_ctrl_if bus();

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pc_q           (pc_q),
    .pc_le          (pc_le),
    .pc_d           (pc_d),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Combinational DUT outputs are captured mid-cycle so the posedge models never race them.
  logic        s_rst, s_le, s_acc;
  logic [31:0] s_d, s_addr;
  logic [31:0] q[$];

  always @(negedge clk) begin
    s_rst  = reset;
    s_le   = pc_le;
    s_d    = pc_d;
    s_acc  = bus.req_valid && bus.req_ready;
    s_addr = bus.req_addr;
  end

  always @(posedge clk) begin
    if (s_le) pc_q <= s_d;
    if (!s_rst) begin
      q.delete();
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      if (s_acc) q.push_back(s_addr);
      if (rsp_en && q.size() > 0) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= memf(q.pop_front());
      end else begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b0; bus.req_ready = 1'b1; rsp_en = 1'b1; if_ready = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // reset held low, then released
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_pc_le", pc_le, 1);
      chk("rst_pc_d", pc_d, 32'h0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_req_valid", bus.req_valid, 0);
    end
    reset = 1'b1; #1;
    chk("rel_req_valid", bus.req_valid, 1);
    chk("rel_req_addr", bus.req_addr, 32'h0);
    chk("rel_pc_le", pc_le, 1);
    chk("rel_pc_d", pc_d, 32'h4);

    // streaming with one-cycle memory
    cyc(); #1;
    chk("s_req_addr4", bus.req_addr, 32'h4);
    chk("s_no_bypass", if_valid, 0);
    cyc(); #1;
    chk("s_valid0", if_valid, 1);
    chk("s_pc0", if_pc, 32'h0);
    chk("s_instr0", if_instr, 32'hC0DE0000);
    chk("s_req_addr8", bus.req_addr, 32'h8);
    cyc(); #1;
    chk("s_pc4", if_pc, 32'h4);
    chk("s_instr4", if_instr, 32'hC0DE0004);
    cyc(); #1;
    chk("s_pc8", if_pc, 32'h8);
    cyc(); #1;
    chk("s_valid12", if_valid, 1);
    chk("s_pc12", if_pc, 32'hC);
    chk("s_instr12", if_instr, 32'hC0DE000C);

    // decode back-pressure
    reset = 1'b0; if_ready = 1'b0;
    cyc(); reset = 1'b1; #1;
    chk("bp_req_addr0", bus.req_addr, 32'h0);
    cyc(); #1;
    chk("bp_req_addr4", bus.req_addr, 32'h4);
    cyc(); #1;
    chk("bp_valid", if_valid, 1);
    chk("bp_pc0", if_pc, 32'h0);
    chk("bp_req_off", bus.req_valid, 0);
    chk("bp_pc_le", pc_le, 0);
    cyc(); #1;
    chk("bp_pc0_held", if_pc, 32'h0);
    chk("bp_req_off2", bus.req_valid, 0);
    chk("bp_pc_q8", pc_q, 32'h8);
    cyc(); if_ready = 1'b1; #1;
    chk("bp_res_pc0", if_pc, 32'h0);
    chk("bp_res_req", bus.req_valid, 1);
    chk("bp_res_addr8", bus.req_addr, 32'h8);
    cyc(); #1;
    chk("bp_res_pc4", if_pc, 32'h4);
    chk("bp_res_addr12", bus.req_addr, 32'hC);
    cyc(); #1;
    chk("bp_res_pc8", if_pc, 32'h8);
    chk("bp_res_instr8", if_instr, 32'hC0DE0008);

    // redirect with two responses outstanding
    reset = 1'b0; rsp_en = 1'b0;
    cyc(); reset = 1'b1; #1;
    chk("rd_req_addr0", bus.req_addr, 32'h0);
    cyc(); #1;
    chk("rd_req_addr4", bus.req_addr, 32'h4);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; rsp_en = 1'b1; #1;
    chk("rd_req_off", bus.req_valid, 0);
    chk("rd_pc_le", pc_le, 1);
    chk("rd_pc_d", pc_d, 32'h100);
    cyc(); redirect_valid = 1'b0; #1;
    chk("rd_flushed", if_valid, 0);
    chk("rd_pc_q", pc_q, 32'h100);
    chk("rd_req_100", bus.req_addr, 32'h100);
    cyc(); #1;
    chk("rd_drop2", if_valid, 0);
    chk("rd_req_104", bus.req_addr, 32'h104);
    cyc(); #1;
    chk("rd_not_ready", if_valid, 0);
    cyc(); #1;
    chk("rd_valid", if_valid, 1);
    chk("rd_pc100", if_pc, 32'h100);
    chk("rd_instr100", if_instr, 32'hC0DE0100);
    cyc(); #1;
    chk("rd_pc104", if_pc, 32'h104);
    chk("rd_instr104", if_instr, 32'hC0DE0104);

    // hazard stall
    reset = 1'b0;
    cyc(); reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
    chk("st_redir_off", bus.req_valid, 0);
    cyc(); redirect_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_pc_le", pc_le, 0);
      chk("st_req_off", bus.req_valid, 0);
      chk("st_pc_q", pc_q, 32'h20);
      cyc();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("st_redir_le", pc_le, 1);
    chk("st_redir_d", pc_d, 32'h40);
    chk("st_redir_req", bus.req_valid, 0);
    cyc(); redirect_valid = 1'b0; stall = 1'b0; #1;
    chk("st_pc_q40", pc_q, 32'h40);
    chk("st_req_40", bus.req_addr, 32'h40);
    chk("st_req_on", bus.req_valid, 1);
    cyc(); stall = 1'b1; #1;
    chk("st2_req_off", bus.req_valid, 0);
    chk("st2_pc_le", pc_le, 0);
    cyc(); #1;
    chk("st2_out_valid", if_valid, 1);
    chk("st2_out_pc", if_pc, 32'h40);
    chk("st2_out_instr", if_instr, 32'hC0DE0040);
    cyc(); stall = 1'b0; #1;
    chk("st2_popped", if_valid, 0);
    chk("st2_req_44", bus.req_addr, 32'h44);

    // PC wrap, then reset mid-stream
    reset = 1'b0;
    cyc(); reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    cyc(); redirect_valid = 1'b0; #1;
    chk("wr_req_addr", bus.req_addr, 32'hFFFF_FFFC);
    chk("wr_pc_le", pc_le, 1);
    chk("wr_pc_d", pc_d, 32'h0);
    cyc(); #1;
    chk("wr_pc_q0", pc_q, 32'h0);
    chk("wr_req_0", bus.req_addr, 32'h0);
    cyc(); #1;
    chk("wr_valid", if_valid, 1);
    chk("wr_pc", if_pc, 32'hFFFF_FFFC);
    chk("wr_instr", if_instr, 32'hC0DE_FFFC);
    reset = 1'b0; #1;
    chk("mr_if_valid", if_valid, 0);
    chk("mr_req_off", bus.req_valid, 0);
    chk("mr_pc_d", pc_d, 32'h0);
    chk("mr_pc_le", pc_le, 1);
    cyc(); #1;
    chk("mr2_if_valid", if_valid, 0);
    chk("mr2_req_off", bus.req_valid, 0);
    chk("mr2_pc_q", pc_q, 32'h0);
    cyc(); reset = 1'b1; #1;
    chk("mr_first_req", bus.req_valid, 1);
    chk("mr_first_addr", bus.req_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
